// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with modulo limit, parallel load and wrap or
// saturate overflow handling; registered count and one-cycle ovf pulse.
module updown_counter_param #(
    parameter int                WIDTH    = 3,
    parameter longint unsigned   MAX      = (64'd1 << WIDTH) - 64'd1,
    parameter bit                SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_zero,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_V = MAX[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;

    // Boundary decisions compare the current count, so MAX = 2**WIDTH-1 needs no carry bit.
    always_comb begin
        count_d = count_q;
        ovf_d   = 1'b0;
        if (load) begin
            count_d = (din > MAX_V) ? MAX_V : din;
        end else if (en) begin
            if (up) begin
                if (count_q == MAX_V) begin
                    ovf_d   = 1'b1;
                    count_d = SATURATE ? MAX_V : '0;
                end else begin
                    count_d = count_q + ONE;
                end
            end else begin
                if (count_q == '0) begin
                    ovf_d   = 1'b1;
                    count_d = SATURATE ? '0 : MAX_V;
                end else begin
                    count_d = count_q - ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count   = count_q;
    assign ovf     = ovf_q;
    assign at_max  = (count_q == MAX_V);
    assign at_zero = (count_q == '0);

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param: three configurations driven in parallel,
// checked every cycle against an arithmetic model plus directed literal checks.
module tb_updown_counter_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0, en = 1'b0, up = 1'b0, load = 1'b0;
    logic [2:0] din = '0;

    logic [2:0] cnt [3];
    logic       amax [3], azero [3], ovf [3];

    // Instance 0: MAX=7 wrap, 1: MAX=5 wrap, 2: MAX=5 saturate.
    int maxv [3] = '{7, 5, 5};
    int satv [3] = '{0, 0, 1};
    int mc [3];
    int mo [3];
    bit model_ok = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    updown_counter_param #(.WIDTH(3), .MAX(7), .SATURATE(1'b0)) u_a (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din),
        .count(cnt[0]), .at_max(amax[0]), .at_zero(azero[0]), .ovf(ovf[0]));
    updown_counter_param #(.WIDTH(3), .MAX(5), .SATURATE(1'b0)) u_b (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din),
        .count(cnt[1]), .at_max(amax[1]), .at_zero(azero[1]), .ovf(ovf[1]));
    updown_counter_param #(.WIDTH(3), .MAX(5), .SATURATE(1'b1)) u_c (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din),
        .count(cnt[2]), .at_max(amax[2]), .at_zero(azero[2]), .ovf(ovf[2]));

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the counting rules expressed as plain integer arithmetic.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                mc[i] = 0;
                mo[i] = 0;
            end else if (load) begin
                mc[i] = (int'(din) > maxv[i]) ? maxv[i] : int'(din);
                mo[i] = 0;
            end else if (en) begin
                int nxt;
                nxt = up ? mc[i] + 1 : mc[i] - 1;
                if (nxt > maxv[i] || nxt < 0) begin
                    mo[i] = 1;
                    if (satv[i] == 0) mc[i] = (nxt < 0) ? maxv[i] : 0;
                end else begin
                    mo[i] = 0;
                    mc[i] = nxt;
                end
            end else begin
                mo[i] = 0;
            end
        end
        if (rst) model_ok = 1'b1;
    end

    always @(posedge clk) begin
        #2;
        if (model_ok) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("model_count[%0d]", i), int'(cnt[i]), mc[i]);
                chk($sformatf("model_ovf[%0d]", i), int'(ovf[i]), mo[i]);
                chk($sformatf("model_at_max[%0d]", i), int'(amax[i]), int'(mc[i] == maxv[i]));
                chk($sformatf("model_at_zero[%0d]", i), int'(azero[i]), int'(mc[i] == 0));
            end
        end
    end

    task automatic cyc(input logic r, input logic l, input logic e, input logic u,
                       input logic [2:0] d);
        rst = r; load = l; en = e; up = u; din = d;
        @(posedge clk);
        #1;
    endtask

    int exp_a [9] = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
    int exp_b [9] = '{1, 2, 3, 4, 5, 0, 1, 2, 3};
    int exp_c [9] = '{1, 2, 3, 4, 5, 5, 5, 5, 5};
    int exp_bd [3] = '{5, 4, 3};

    initial begin
        // Reset held two edges with en/up active.
        cyc(1, 0, 1, 1, 0);
        cyc(1, 0, 1, 1, 0);
        chk("rst_count", int'(cnt[0]), 0);
        chk("rst_ovf", int'(ovf[0]), 0);
        chk("rst_at_zero", int'(azero[0]), 1);
        chk("rst_at_max", int'(amax[2]), 0);

        // Count up: wrap at 7, wrap at 5, saturate at 5.
        for (int k = 0; k < 9; k++) begin
            cyc(0, 0, 1, 1, 0);
            chk("up_a_count", int'(cnt[0]), exp_a[k]);
            chk("up_a_ovf", int'(ovf[0]), int'(k == 7));
            chk("up_b_count", int'(cnt[1]), exp_b[k]);
            chk("up_b_ovf", int'(ovf[1]), int'(k == 5));
            chk("up_b_at_max", int'(amax[1]), int'(k == 4));
            chk("up_c_count", int'(cnt[2]), exp_c[k]);
            chk("up_c_ovf", int'(ovf[2]), int'(k >= 5));
        end
        cyc(0, 0, 1, 0, 0);
        chk("sat_release_count", int'(cnt[2]), 4);
        chk("sat_release_ovf", int'(ovf[2]), 0);
        chk("rev_b_count", int'(cnt[1]), 2);

        // Count down from zero.
        cyc(1, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 1, 0, 0);
            chk("dn_b_count", int'(cnt[1]), exp_bd[k]);
            chk("dn_b_ovf", int'(ovf[1]), int'(k == 0));
            chk("dn_c_count", int'(cnt[2]), 0);
            chk("dn_c_ovf", int'(ovf[2]), 1);
        end
        chk("dn_a_count", int'(cnt[0]), 5);

        // Load beats enable; load above MAX clamps.
        cyc(0, 1, 1, 1, 3);
        chk("load_count", int'(cnt[0]), 3);
        chk("load_ovf", int'(ovf[2]), 0);
        cyc(0, 1, 0, 0, 7);
        chk("clamp_b_count", int'(cnt[1]), 5);
        chk("clamp_b_at_max", int'(amax[1]), 1);
        chk("clamp_b_ovf", int'(ovf[1]), 0);
        chk("clamp_a_count", int'(cnt[0]), 7);

        // Hold with en low while toggling up.
        for (int k = 0; k < 4; k++) begin
            cyc(0, 0, 0, k[0], 0);
            chk("hold_count", int'(cnt[1]), 5);
            chk("hold_ovf", int'(ovf[1]), 0);
        end
        cyc(0, 1, 0, 0, 2);
        cyc(0, 0, 1, 1, 0);
        chk("rev_up", int'(cnt[0]), 3);
        cyc(0, 0, 1, 0, 0);
        chk("rev_dn", int'(cnt[0]), 2);

        // Reset overrides load and enable on the same edge.
        cyc(0, 1, 0, 0, 5);
        cyc(1, 1, 1, 1, 4);
        chk("rst_mid_count", int'(cnt[1]), 0);
        chk("rst_mid_ovf", int'(ovf[1]), 0);

        // Randomised traffic checked by the model.
        for (int k = 0; k < 600; k++) begin
            cyc(($urandom_range(31) == 0), ($urandom_range(7) == 0),
                ($urandom_range(3) != 0), 1'($urandom), 3'($urandom));
        end

        cyc(0, 0, 0, 0, 0);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
